// File: rtl/ex_stage_pkg.sv
// rtl/ex_stage_pkg.sv - shared execute-stage types: ALU/M-op codes, md FSM states, forwarding select, control vector
package ex_stage_pkg;

  typedef enum logic [3:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR,
    ALU_SRL, ALU_SRA, ALU_OR, ALU_AND, ALU_PASSB
  } alu_op_e;

  // Encoded in RV32M funct3 order so bit 2 separates divide from multiply.
  typedef enum logic [2:0] {
    MD_MUL, MD_MULH, MD_MULHSU, MD_MULHU, MD_DIV, MD_DIVU, MD_REM, MD_REMU
  } md_op_e;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} md_state_e;

  typedef enum logic [1:0] {REG, MEM, WB} fwd_sel_e;

  typedef struct packed {
    logic    reg_write;
    logic    mem_read;
    logic    mem_write;
    logic    alu_src;
    alu_op_e alu_op;
    logic    branch;
    logic [2:0] funct3;
    logic    jal;
    logic    jalr;
    logic    md_en;
    md_op_e  md_op;
  } riscv_control_t;

endpackage

// File: rtl/ex_stage_if.sv
// rtl/ex_stage_if.sv - ID/EX inputs, forwarding taps and EX/MEM outputs of the execute stage
interface ex_stage_if
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INDEX = 5
) ();

  logic             valid_in;
  logic [WIDTH-1:0] pc_in;
  logic [INDEX-1:0] rs1_in;
  logic [INDEX-1:0] rs2_in;
  logic [INDEX-1:0] rd_in;
  logic [WIDTH-1:0] drs1_in;
  logic [WIDTH-1:0] drs2_in;
  logic [WIDTH-1:0] signimm_in;
  riscv_control_t   ctrl_vector_in;
  logic             fwd_mem_we_in;
  logic [INDEX-1:0] fwd_mem_rd_in;
  logic [WIDTH-1:0] fwd_mem_data_in;
  logic             fwd_wb_we_in;
  logic [INDEX-1:0] fwd_wb_rd_in;
  logic [WIDTH-1:0] fwd_wb_data_in;

  logic             stall_out;
  logic             valid_out;
  logic [WIDTH-1:0] result_out;
  logic [WIDTH-1:0] store_data_out;
  logic [INDEX-1:0] rd_out;
  riscv_control_t   ctrl_vector_out;
  logic             branch_taken_out;
  logic [WIDTH-1:0] branch_target_out;

  modport master (
    output valid_in, pc_in, rs1_in, rs2_in, rd_in, drs1_in, drs2_in, signimm_in,
           ctrl_vector_in, fwd_mem_we_in, fwd_mem_rd_in, fwd_mem_data_in,
           fwd_wb_we_in, fwd_wb_rd_in, fwd_wb_data_in,
    input  stall_out, valid_out, result_out, store_data_out, rd_out,
           ctrl_vector_out, branch_taken_out, branch_target_out
  );

  modport slave (
    input  valid_in, pc_in, rs1_in, rs2_in, rd_in, drs1_in, drs2_in, signimm_in,
           ctrl_vector_in, fwd_mem_we_in, fwd_mem_rd_in, fwd_mem_data_in,
           fwd_wb_we_in, fwd_wb_rd_in, fwd_wb_data_in,
    output stall_out, valid_out, result_out, store_data_out, rd_out,
           ctrl_vector_out, branch_taken_out, branch_target_out
  );

endinterface

// File: rtl/ex_stage_md.sv
// rtl/ex_stage_md.sv - md_unit: iterative shift-add multiplier / restoring divider with IDLE-BUSY-DONE FSM
module md_unit
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  md_op_e           op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o
);

  localparam int CW = $clog2(WIDTH);

  md_state_e        state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  md_op_e           op_q, op_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d, opnd_q, opnd_d, dvd_q, dvd_d;
  logic             neg_q, neg_d, rneg_q, rneg_d, bzero_q, bzero_d;

  logic             a_signed, b_signed, a_neg, b_neg, div_ok, is_div;
  logic [WIDTH-1:0] a_mag, b_mag, quot_fix, rem_fix;
  logic [WIDTH:0]   mul_sum, div_shift;
  logic [2*WIDTH-1:0] prod_fix;

  always_comb begin
    a_signed = (op_i == MD_MUL) || (op_i == MD_MULH) || (op_i == MD_MULHSU) ||
               (op_i == MD_DIV) || (op_i == MD_REM);
    b_signed = (op_i == MD_MUL) || (op_i == MD_MULH) ||
               (op_i == MD_DIV) || (op_i == MD_REM);
    a_neg    = a_signed && a_i[WIDTH-1];
    b_neg    = b_signed && b_i[WIDTH-1];
    a_mag    = a_neg ? -a_i : a_i;
    b_mag    = b_neg ? -b_i : b_i;
  end

  // lo_q holds the multiplier (mul) or the shifting dividend/quotient (div).
  assign mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opnd_q} : '0);
  assign div_shift = {hi_q, lo_q[WIDTH-1]};
  assign div_ok    = div_shift >= {1'b0, opnd_q};
  assign is_div    = (op_q == MD_DIV) || (op_q == MD_DIVU) ||
                     (op_q == MD_REM) || (op_q == MD_REMU);

  assign prod_fix = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
  assign quot_fix = neg_q ? -lo_q : lo_q;
  assign rem_fix  = rneg_q ? -hi_q : hi_q;

  always_comb begin
    case (op_q)
      MD_MUL:                       result_o = prod_fix[WIDTH-1:0];
      MD_MULH, MD_MULHSU, MD_MULHU: result_o = prod_fix[2*WIDTH-1:WIDTH];
      MD_DIV, MD_DIVU:              result_o = bzero_q ? '1 : quot_fix;
      default:                      result_o = bzero_q ? dvd_q : rem_fix;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    opnd_d  = opnd_q;
    dvd_d   = dvd_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    bzero_d = bzero_q;
    busy_o  = 1'b0;
    done_o  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          busy_o  = 1'b1;
          op_d    = op_i;
          hi_d    = '0;
          lo_d    = a_mag;
          opnd_d  = b_mag;
          dvd_d   = a_i;
          neg_d   = a_neg ^ b_neg;
          rneg_d  = a_neg;
          bzero_d = (b_i == '0);
          cnt_d   = CW'(WIDTH - 1);
          state_d = BUSY;
        end
      end
      BUSY: begin
        busy_o = 1'b1;
        if (is_div) begin
          hi_d = div_ok ? (div_shift[WIDTH-1:0] - opnd_q) : div_shift[WIDTH-1:0];
          lo_d = {lo_q[WIDTH-2:0], div_ok};
        end else begin
          hi_d = mul_sum[WIDTH:1];
          lo_d = {mul_sum[0], lo_q[WIDTH-1:1]};
        end
        cnt_d = cnt_q - 1'b1;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        done_o  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= MD_MUL;
      hi_q    <= '0;
      lo_q    <= '0;
      opnd_q  <= '0;
      dvd_q   <= '0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      bzero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      opnd_q  <= opnd_d;
      dvd_q   <= dvd_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      bzero_q <= bzero_d;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - execute stage: forwarding, ALU, branch/jump resolution; RV32M_EN adds iterative mul/div
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int INDEX = 5
) (
  input  logic      clk_in,
  input  logic      rst_in,
  ex_stage_if.slave bus
);

  riscv_control_t   ctrl;
  fwd_sel_e         sel_rs1, sel_rs2;
  logic [WIDTH-1:0] rs1_val, rs2_val, op_b, alu_res, pc_plus4, jalr_tgt;
  logic [4:0]       shamt;
  logic             br_cond;

  logic             valid_q, valid_d, taken_q, taken_d;
  logic [WIDTH-1:0] result_q, result_d, store_q, store_d, target_q, target_d;
  logic [INDEX-1:0] rd_q, rd_d;
  riscv_control_t   ctrl_q, ctrl_d;

  assign ctrl = bus.ctrl_vector_in;

  // MEM is the younger producer, so it wins over WB; x0 never forwards.
  always_comb begin
    sel_rs1 = REG;
    sel_rs2 = REG;
    if (bus.fwd_mem_we_in && bus.fwd_mem_rd_in == bus.rs1_in && bus.fwd_mem_rd_in != '0)
      sel_rs1 = MEM;
    else if (bus.fwd_wb_we_in && bus.fwd_wb_rd_in == bus.rs1_in && bus.fwd_wb_rd_in != '0)
      sel_rs1 = WB;
    if (bus.fwd_mem_we_in && bus.fwd_mem_rd_in == bus.rs2_in && bus.fwd_mem_rd_in != '0)
      sel_rs2 = MEM;
    else if (bus.fwd_wb_we_in && bus.fwd_wb_rd_in == bus.rs2_in && bus.fwd_wb_rd_in != '0)
      sel_rs2 = WB;
  end

  always_comb begin
    case (sel_rs1)
      MEM:     rs1_val = bus.fwd_mem_data_in;
      WB:      rs1_val = bus.fwd_wb_data_in;
      default: rs1_val = bus.drs1_in;
    endcase
    case (sel_rs2)
      MEM:     rs2_val = bus.fwd_mem_data_in;
      WB:      rs2_val = bus.fwd_wb_data_in;
      default: rs2_val = bus.drs2_in;
    endcase
  end

  assign op_b     = ctrl.alu_src ? bus.signimm_in : rs2_val;
  assign shamt    = op_b[4:0];
  assign pc_plus4 = bus.pc_in + WIDTH'(4);
  assign jalr_tgt = (rs1_val + bus.signimm_in) & ~WIDTH'(1);

  always_comb begin
    case (ctrl.alu_op)
      ALU_ADD:   alu_res = rs1_val + op_b;
      ALU_SUB:   alu_res = rs1_val - op_b;
      ALU_SLL:   alu_res = rs1_val << shamt;
      ALU_SLT:   alu_res = {{(WIDTH-1){1'b0}}, $signed(rs1_val) < $signed(op_b)};
      ALU_SLTU:  alu_res = {{(WIDTH-1){1'b0}}, rs1_val < op_b};
      ALU_XOR:   alu_res = rs1_val ^ op_b;
      ALU_SRL:   alu_res = rs1_val >> shamt;
      ALU_SRA:   alu_res = $unsigned($signed(rs1_val) >>> shamt);
      ALU_OR:    alu_res = rs1_val | op_b;
      ALU_AND:   alu_res = rs1_val & op_b;
      ALU_PASSB: alu_res = op_b;
      default:   alu_res = '0;
    endcase
  end

  always_comb begin
    case (ctrl.funct3)
      3'b000:  br_cond = (rs1_val == rs2_val);
      3'b001:  br_cond = (rs1_val != rs2_val);
      3'b100:  br_cond = ($signed(rs1_val) <  $signed(rs2_val));
      3'b101:  br_cond = ($signed(rs1_val) >= $signed(rs2_val));
      3'b110:  br_cond = (rs1_val <  rs2_val);
      3'b111:  br_cond = (rs1_val >= rs2_val);
      default: br_cond = 1'b0;
    endcase
  end

`ifdef RV32M_EN
  logic             md_busy, md_done;
  logic [WIDTH-1:0] md_result;

  md_unit #(.WIDTH(WIDTH)) u_md (
    .clk_i    (clk_in),
    .rst_ni   (rst_in),
    .start_i  (bus.valid_in && ctrl.md_en),
    .op_i     (ctrl.md_op),
    .a_i      (rs1_val),
    .b_i      (rs2_val),
    .busy_o   (md_busy),
    .done_o   (md_done),
    .result_o (md_result)
  );

  assign bus.stall_out = md_busy;
`else
  assign bus.stall_out = 1'b0;
`endif

  always_comb begin
    valid_d  = 1'b0;
    result_d = '0;
    store_d  = '0;
    rd_d     = '0;
    ctrl_d   = '0;
    taken_d  = 1'b0;
    target_d = '0;
    if (bus.valid_in) begin
      if (ctrl.md_en) begin
`ifdef RV32M_EN
        // Start and BUSY cycles issue bubbles; the ID/EX fields are still held in DONE.
        if (md_done) begin
          valid_d  = 1'b1;
          result_d = md_result;
          store_d  = rs2_val;
          rd_d     = bus.rd_in;
          ctrl_d   = ctrl;
        end
`else
        valid_d  = 1'b1;
        store_d  = rs2_val;
        rd_d     = bus.rd_in;
        ctrl_d   = ctrl;
`endif
      end else begin
        valid_d  = 1'b1;
        result_d = (ctrl.jal || ctrl.jalr) ? pc_plus4 : alu_res;
        store_d  = rs2_val;
        rd_d     = bus.rd_in;
        ctrl_d   = ctrl;
        taken_d  = ctrl.jal || ctrl.jalr || (ctrl.branch && br_cond);
        target_d = ctrl.jalr ? jalr_tgt : (bus.pc_in + bus.signimm_in);
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      valid_q  <= 1'b0;
      result_q <= '0;
      store_q  <= '0;
      rd_q     <= '0;
      ctrl_q   <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      valid_q  <= valid_d;
      result_q <= result_d;
      store_q  <= store_d;
      rd_q     <= rd_d;
      ctrl_q   <= ctrl_d;
      taken_q  <= taken_d;
      target_q <= target_d;
    end
  end

  assign bus.valid_out         = valid_q;
  assign bus.result_out        = result_q;
  assign bus.store_data_out    = store_q;
  assign bus.rd_out            = rd_q;
  assign bus.ctrl_vector_out   = ctrl_q;
  assign bus.branch_taken_out  = taken_q;
  assign bus.branch_target_out = target_q;

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - randomized self-checking bench for ex_stage against a behavioural model
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    ex_stage_if #(.WIDTH(32), .INDEX(5)) ex_bus ();

    ex_stage #(.WIDTH(32), .INDEX(5)) dut (
        .clk_in (clk),
        .rst_in (rst_n),
        .bus    (ex_bus)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_inputs();
        ex_bus.valid_in        = 1'b0;
        ex_bus.pc_in           = '0;
        ex_bus.rs1_in          = '0;
        ex_bus.rs2_in          = '0;
        ex_bus.rd_in           = '0;
        ex_bus.drs1_in         = '0;
        ex_bus.drs2_in         = '0;
        ex_bus.signimm_in      = '0;
        ex_bus.ctrl_vector_in  = '0;
        ex_bus.fwd_mem_we_in   = 1'b0;
        ex_bus.fwd_mem_rd_in   = '0;
        ex_bus.fwd_mem_data_in = '0;
        ex_bus.fwd_wb_we_in    = 1'b0;
        ex_bus.fwd_wb_rd_in    = '0;
        ex_bus.fwd_wb_data_in  = '0;
    endtask

    task automatic set_op(input riscv_control_t c, input logic [31:0] pc, input logic [4:0] rs1,
                          input logic [4:0] rs2, input logic [4:0] rd, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] imm);
        clear_inputs();
        ex_bus.valid_in       = 1'b1;
        ex_bus.ctrl_vector_in = c;
        ex_bus.pc_in          = pc;
        ex_bus.rs1_in         = rs1;
        ex_bus.rs2_in         = rs2;
        ex_bus.rd_in          = rd;
        ex_bus.drs1_in        = d1;
        ex_bus.drs2_in        = d2;
        ex_bus.signimm_in     = imm;
    endtask

    function automatic logic [31:0] fwd_model(input logic [4:0] rs, input logic [31:0] regval);
        if (rs != 0 && ex_bus.fwd_mem_we_in && ex_bus.fwd_mem_rd_in == rs) return ex_bus.fwd_mem_data_in;
        if (rs != 0 && ex_bus.fwd_wb_we_in && ex_bus.fwd_wb_rd_in == rs) return ex_bus.fwd_wb_data_in;
        return regval;
    endfunction

    function automatic logic [31:0] md_model(input md_op_e op, input logic [31:0] a, input logic [31:0] b);
        longint     sp;
        logic [63:0] up;
        case (op)
            MD_MUL:    begin up = 64'(a) * 64'(b); return up[31:0]; end
            MD_MULH:   begin sp = longint'($signed(a)) * longint'($signed(b)); up = sp; return up[63:32]; end
            MD_MULHSU: begin sp = longint'($signed(a)) * longint'({32'b0, b}); up = sp; return up[63:32]; end
            MD_MULHU:  begin up = 64'(a) * 64'(b); return up[63:32]; end
            MD_DIV:    begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(int'(a) / int'(b));
            end
            MD_DIVU:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            MD_REM:    begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(int'(a) % int'(b));
            end
            default:   return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic check_outputs_zero(input string tag);
        check({tag, ".valid"}, ex_bus.valid_out, 0);
        check({tag, ".result"}, ex_bus.result_out, 0);
        check({tag, ".store"}, ex_bus.store_data_out, 0);
        check({tag, ".rd"}, ex_bus.rd_out, 0);
        check({tag, ".ctrl"}, ex_bus.ctrl_vector_out, 0);
        check({tag, ".taken"}, ex_bus.branch_taken_out, 0);
        check({tag, ".target"}, ex_bus.branch_target_out, 0);
        check({tag, ".stall"}, ex_bus.stall_out, 0);
    endtask

    // Called with a non-M op already on the inputs; returns just after the capturing edge.
    task automatic check_alu(input string tag);
        riscv_control_t c;
        logic [31:0] a, b, rs2v, exp_res, exp_tgt;
        logic        exp_taken, cond;
        c    = ex_bus.ctrl_vector_in;
        a    = fwd_model(ex_bus.rs1_in, ex_bus.drs1_in);
        rs2v = fwd_model(ex_bus.rs2_in, ex_bus.drs2_in);
        b    = c.alu_src ? ex_bus.signimm_in : rs2v;
        case (c.alu_op)
            ALU_ADD:  exp_res = a + b;
            ALU_SUB:  exp_res = a - b;
            ALU_SLL:  exp_res = a << b[4:0];
            ALU_SLT:  exp_res = (int'(a) < int'(b)) ? 1 : 0;
            ALU_SLTU: exp_res = (a < b) ? 1 : 0;
            ALU_XOR:  exp_res = a ^ b;
            ALU_SRL:  exp_res = a >> b[4:0];
            ALU_SRA:  exp_res = 32'(int'(a) >>> b[4:0]);
            ALU_OR:   exp_res = a | b;
            ALU_AND:  exp_res = a & b;
            default:  exp_res = b;
        endcase
        case (c.funct3)
            3'd0: cond = (a == rs2v);
            3'd1: cond = (a != rs2v);
            3'd4: cond = (int'(a) < int'(rs2v));
            3'd5: cond = (int'(a) >= int'(rs2v));
            3'd6: cond = (a < rs2v);
            default: cond = (a >= rs2v);
        endcase
        if (c.jal || c.jalr) exp_res = ex_bus.pc_in + 4;
        exp_taken = ex_bus.valid_in && (c.jal || c.jalr || (c.branch && cond));
        exp_tgt   = c.jalr ? ((a + ex_bus.signimm_in) & 32'hFFFF_FFFE) : (ex_bus.pc_in + ex_bus.signimm_in);
        #1;
        check({tag, ".stall"}, ex_bus.stall_out, 0);
        @(posedge clk);
        #1;
        check({tag, ".valid"}, ex_bus.valid_out, ex_bus.valid_in);
        check({tag, ".ctrl"}, ex_bus.ctrl_vector_out, ex_bus.valid_in ? c : '0);
        check({tag, ".taken"}, ex_bus.branch_taken_out, exp_taken);
        if (ex_bus.valid_in) begin
            check({tag, ".rd"}, ex_bus.rd_out, ex_bus.rd_in);
            check({tag, ".store"}, ex_bus.store_data_out, rs2v);
            if (!c.branch) check({tag, ".result"}, ex_bus.result_out, exp_res);
        end
        if (exp_taken) check({tag, ".target"}, ex_bus.branch_target_out, exp_tgt);
    endtask

    // M op already on the inputs; returns after the result edge with a bubble driven.
    task automatic run_md(input string tag, output logic [31:0] got);
        riscv_control_t c;
        logic [31:0] exp_res, rs2v;
        int          stall_cycles;
        logic        bubble_bad;
        c       = ex_bus.ctrl_vector_in;
        rs2v    = fwd_model(ex_bus.rs2_in, ex_bus.drs2_in);
        exp_res = md_model(c.md_op, fwd_model(ex_bus.rs1_in, ex_bus.drs1_in), rs2v);
`ifndef RV32M_EN
        exp_res = 0;
`endif
        stall_cycles = 0;
        bubble_bad   = 1'b0;
        #1;
        while (ex_bus.stall_out && stall_cycles < 100) begin
            stall_cycles++;
            @(posedge clk);
            #1;
            if (ex_bus.valid_out) bubble_bad = 1'b1;
        end
`ifdef RV32M_EN
        check({tag, ".stall_len"}, stall_cycles, 33);
`else
        check({tag, ".stall_len"}, stall_cycles, 0);
`endif
        check({tag, ".bubble"}, bubble_bad, 0);
        @(posedge clk);
        #1;
        got = ex_bus.result_out;
        check({tag, ".valid"}, ex_bus.valid_out, 1);
        check({tag, ".result"}, ex_bus.result_out, exp_res);
        check({tag, ".rd"}, ex_bus.rd_out, ex_bus.rd_in);
        check({tag, ".store"}, ex_bus.store_data_out, rs2v);
        check({tag, ".ctrl"}, ex_bus.ctrl_vector_out, c);
        ex_bus.valid_in = 1'b0;
    endtask

    function automatic riscv_control_t md_ctrl(input md_op_e op);
        riscv_control_t c;
        c           = '0;
        c.reg_write = 1'b1;
        c.md_en     = 1'b1;
        c.md_op     = op;
        return c;
    endfunction

    task automatic md_directed(input string tag, input md_op_e op, input logic [31:0] a,
                               input logic [31:0] b, input logic [31:0] lit);
        logic [31:0] got;
        @(negedge clk);
        set_op(md_ctrl(op), 32'h100, 5'd3, 5'd4, 5'd9, a, b, 32'h0);
        run_md(tag, got);
`ifdef RV32M_EN
        check({tag, ".lit"}, got, lit);
`else
        check({tag, ".lit"}, got, 0 & lit);
`endif
    endtask

    task automatic rand_fwd();
        ex_bus.fwd_mem_we_in   = 1'($urandom_range(0, 1));
        ex_bus.fwd_mem_rd_in   = 5'($urandom_range(0, 7));
        ex_bus.fwd_mem_data_in = $urandom;
        ex_bus.fwd_wb_we_in    = 1'($urandom_range(0, 1));
        ex_bus.fwd_wb_rd_in    = 5'($urandom_range(0, 7));
        ex_bus.fwd_wb_data_in  = $urandom;
    endtask

    task automatic rand_alu_op();
        riscv_control_t c;
        logic [2:0]     f3_tab [6];
        int             kind;
        f3_tab = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        c           = '0;
        c.alu_op    = alu_op_e'($urandom_range(0, 10));
        c.alu_src   = 1'($urandom_range(0, 1));
        c.reg_write = 1'($urandom_range(0, 1));
        c.mem_read  = 1'($urandom_range(0, 1));
        kind = $urandom_range(0, 9);
        if (kind == 6) begin c.branch = 1'b1; c.funct3 = f3_tab[$urandom_range(0, 5)]; end
        if (kind == 7) c.jal = 1'b1;
        if (kind == 8) c.jalr = 1'b1;
        set_op(c, $urandom & 32'hFFFF_FFFC, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
               5'($urandom_range(0, 31)), $urandom, $urandom, $urandom);
        if ($urandom_range(0, 3) == 0) ex_bus.drs2_in = ex_bus.drs1_in;
        if ($urandom_range(0, 3) == 0) ex_bus.signimm_in = 32'($urandom_range(0, 40));
        rand_fwd();
        ex_bus.valid_in = ($urandom_range(0, 9) != 0);
    endtask

    riscv_control_t c0;
    logic [31:0]    got_md;

    initial begin
        clear_inputs();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        @(negedge clk);
        c0 = '0; c0.reg_write = 1'b1; c0.alu_op = ALU_ADD;
        set_op(c0, 32'h0, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0);
        check_alu("add");
        check("add.lit", ex_bus.result_out, 12);

        @(negedge clk);
        c0.alu_src = 1'b1;
        set_op(c0, 32'h4, 5'd1, 5'd0, 5'd4, 32'h11, 32'h0, 32'd1);
        ex_bus.fwd_mem_we_in = 1'b1; ex_bus.fwd_mem_rd_in = 5'd1; ex_bus.fwd_mem_data_in = 32'd100;
        ex_bus.fwd_wb_we_in  = 1'b1; ex_bus.fwd_wb_rd_in  = 5'd1; ex_bus.fwd_wb_data_in  = 32'd50;
        check_alu("fwd_mem");
        check("fwd_mem.lit", ex_bus.result_out, 101);

        @(negedge clk);
        ex_bus.fwd_mem_we_in = 1'b0;
        check_alu("fwd_wb");
        check("fwd_wb.lit", ex_bus.result_out, 51);

        @(negedge clk);
        ex_bus.rs1_in = 5'd0;
        ex_bus.fwd_mem_we_in = 1'b1; ex_bus.fwd_mem_rd_in = 5'd0;
        ex_bus.fwd_wb_rd_in  = 5'd0;
        check_alu("fwd_x0");
        check("fwd_x0.lit", ex_bus.result_out, 32'h12);

        @(negedge clk);
        c0 = '0; c0.branch = 1'b1; c0.funct3 = 3'd0;
        set_op(c0, 32'h40, 5'd1, 5'd2, 5'd0, 32'd8, 32'd8, 32'h10);
        check_alu("beq");
        check("beq.taken_lit", ex_bus.branch_taken_out, 1);
        check("beq.target_lit", ex_bus.branch_target_out, 32'h50);

        @(negedge clk);
        c0 = '0; c0.jalr = 1'b1; c0.alu_src = 1'b1; c0.reg_write = 1'b1;
        set_op(c0, 32'h200, 5'd5, 5'd0, 5'd1, 32'h103, 32'h0, 32'h0);
        check_alu("jalr");
        check("jalr.target_lit", ex_bus.branch_target_out, 32'h102);
        check("jalr.link_lit", ex_bus.result_out, 32'h204);

        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            rand_alu_op();
            check_alu($sformatf("rnd%0d", i));
        end

        md_directed("div_m7_2", MD_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
        md_directed("rem_m7_2", MD_REM, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
        md_directed("divu_x0", MD_DIVU, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
        md_directed("rem_x0", MD_REM, 32'hFFFF_FF00, 32'd0, 32'hFFFF_FF00);
        md_directed("div_ovf", MD_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
        md_directed("rem_ovf", MD_REM, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);
        md_directed("mulhu_max", MD_MULHU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        md_directed("mulh_neg", MD_MULH, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0);

        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            set_op(md_ctrl(md_op_e'($urandom_range(0, 7))), $urandom, 5'($urandom_range(0, 7)),
                   5'($urandom_range(0, 7)), 5'($urandom_range(1, 31)), $urandom,
                   ($urandom_range(0, 4) == 0) ? 32'h0 : 32'($urandom) >> $urandom_range(0, 31),
                   $urandom);
            rand_fwd();
            run_md($sformatf("mdrnd%0d", i), got_md);
        end

        @(negedge clk);
        set_op(md_ctrl(MD_DIV), 32'h300, 5'd3, 5'd4, 5'd7, 32'd1000, 32'd3, 32'h0);
        repeat (10) @(posedge clk);
        @(negedge clk);
        ex_bus.valid_in = 1'b0;
        rst_n = 1'b0;
        #1;
        check_outputs_zero("rst_busy");
        @(negedge clk);
        rst_n = 1'b1;
        c0 = '0; c0.reg_write = 1'b1; c0.alu_op = ALU_ADD;
        set_op(c0, 32'h0, 5'd1, 5'd2, 5'd3, 32'd20, 32'd22, 32'd0);
        check_alu("post_rst");
        check("post_rst.lit", ex_bus.result_out, 42);

        @(negedge clk);
        clear_inputs();
        @(posedge clk);
        #1;
        check("bubble.valid", ex_bus.valid_out, 0);
        check("bubble.ctrl", ex_bus.ctrl_vector_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
